multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle MIPS control unit: the instruction-side driver of the datapath ALU. From the current opcode and the ALU `zero` flag it steps a per-instruction state machine (IF, ID, EXE, MEM, WB). It generates `alu_op[2:0]`, operand-select, memory, register-file and PC control for each cycle. It sits between the instruction register and the datapath in the multi-cycle CPU top.

## Interface
- No parameters. Opcode, state, ALU-op and PC-source encodings come from the shared package.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]; valid from ID onward.
- `zero` input 1: ALU zero flag, combinational from the current `alu_op`.
- `state` output 3: current state, for debug.
- `pc_wre` output 1: PC write enable.
- `pc_src` output 2: 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- `ins_mem_rw` output 1: instruction memory read.
- `ir_wre` output 1: IR load.
- `reg_wre` output 1: register-file write.
- `reg_dst` output 2: 00 $31, 01 rt, 10 rd.
- `wr_reg_d_src` output 1: 0 PC+4, 1 write-back bus.
- `alu_src_a` output 1: 1 selects zero-extended sa.
- `alu_src_b` output 1: 1 selects extended immediate.
- `ext_sel` output 1: 0 zero-extend, 1 sign-extend.
- `alu_op` output 3: ALU operation.
- `m_rd` output 1: data-memory read.
- `m_wr` output 1: data-memory write.
- `db_data_src` output 1: 0 ALU result, 1 memory data.

## Operation
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010001, andi 010000, or 010011, ori 010010, xori 010100, sll 011000
  - slt 100111, slti 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_L 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF→ID.
  - ID→IF for j, jr, jal and undefined opcodes.
  - ID→ID for halt, forever.
  - ID→EXE_BR for beq, bne, bltz.
  - ID→EXE_LS for lw, sw.
  - ID→EXE_AL for all other defined opcodes.
  - EXE_AL→WB_AL→IF. EXE_BR→IF. EXE_LS→MEM.
  - MEM→WB_L for lw; MEM→IF for sw. WB_L→IF.
- `alu_op` mapping:
  - 000: add, addiu, lw, sw
  - 001: sub, beq, bne
  - 010: sll
  - 011: or, ori
  - 100: and, andi
  - 110: slt, slti, bltz (bltz compares rs against $0)
  - 111: xori
- `alu_op` is driven from opcode in every state after IF.
- Operand and extend selects:
  - `alu_src_b`=1: addiu, andi, ori, xori, slti, lw, sw.
  - `alu_src_a`=1: sll only.
  - `ext_sel`=0: andi, ori, xori; 1 otherwise.
- Register destination: `reg_dst`=10 for R-type (add, sub, and, or, slt, sll); 01 for immediates and lw; 00 for jal.
- `pc_wre`=1 in exactly one cycle per instruction, the last: ID (j, jr, jal, undefined), WB_AL, EXE_BR, MEM (sw), WB_L.
- `pc_src` in that cycle:
  - 11 for j, jal; 10 for jr.
  - 01 for beq with `zero`=1, bne with `zero`=0, bltz with `zero`=0.
  - 00 otherwise.
- `reg_wre`=1 only in:
  - WB_AL (`wr_reg_d_src`=1, `db_data_src`=0)
  - WB_L (`wr_reg_d_src`=1, `db_data_src`=1)
  - ID for jal (`wr_reg_d_src`=0, `reg_dst`=00)
- Memory: `m_rd`=1 in MEM for lw only; `m_wr`=1 in MEM for sw only.
- IF: `ins_mem_rw`=1 and `ir_wre`=1. Both are 0 in every other state.
- Undefined opcode behaves as nop: no register or memory write; PC+4.

## Timing
- State register updates on rising `clk`. All outputs are combinational from the registered `state` and `opcode`; `pc_src` for branches also depends on `zero`.
- Cycle counts, including IF: j/jr/jal 2; branches 3; R/I ALU and sw 4; lw 5. Halt never completes.
- While `rst_n`=0: state=IF, so `ins_mem_rw`=`ir_wre`=1 and all write enables (`pc_wre`, `reg_wre`, `m_wr`) are 0. Every other output is 0, except `ext_sel`, which follows its opcode decode. The first fetch begins on the first edge after release.
- Reset asserted mid-instruction: state returns to IF immediately, with no partial write.
- Only reset exits halt. During halt all write enables stay 0.
- `zero` is sampled combinationally in EXE_BR; the branch decision and PC write happen in the same cycle.

## Structure
- Package `mcpu_pkg`: opcode localparams, 3-bit state encodings, ALU-op codes, `pc_src` and `reg_dst` codes. The datapath ALU and muxes share the same constants.
- Sub-module `control_decode`: combinational opcode → {instruction class, `alu_op`, `ext_sel`, `alu_src_a`, `alu_src_b`, `reg_dst`}.
- The top holds the state register, next-state logic and state-qualified enables.

## Test plan
- Reset: `rst_n` low mid-EXE_AL → state=000 immediately; `pc_wre`=`reg_wre`=`m_wr`=0; after release, IF→ID on successive edges.
- add (000000): states 000→001→110→111→000. In 111: `reg_wre`=1, `reg_dst`=10, `alu_op`=000, `pc_wre`=1, `pc_src`=00.
- lw (110001): 5 states, ending at 100. `m_rd`=1 only in 011; `db_data_src`=1 in 100. sw (110000): `m_wr`=1 and `pc_wre`=1 in 011, then back to 000.
- beq with `zero`=1 → `pc_src`=01 in 101; with `zero`=0 → 00. bne and bltz: `zero`=0 → 01.
- jal (111010): in 001, `reg_wre`=1, `reg_dst`=00, `wr_reg_d_src`=0, `pc_src`=11, `pc_wre`=1. jr (111001): `pc_src`=10.
- halt (111111): state stays 001 for 20 cycles with `pc_wre`=0. Undefined opcode 101010: 2 cycles, `pc_src`=00, no writes.

Source files
------------

// File: rtl/mcpu_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_pkg
// Constants shared by the multi-cycle MIPS control unit and its datapath:
// opcodes, FSM state encodings, ALU operation codes, PC-source and
// register-destination selects, and the instruction classes used by the
// control sequencer.
// ---------------------------------------------------------------------------
package mcpu_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_XORI  = 6'b010100;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_L   = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_e;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // Next-PC selects
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_RS     = 2'b10;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b11;

  // Register-file write destination selects
  localparam logic [1:0] REG_DST_RA = 2'b00;
  localparam logic [1:0] REG_DST_RT = 2'b01;
  localparam logic [1:0] REG_DST_RD = 2'b10;

  // Instruction classes steering the sequencer
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_HALT   = 3'd5,
    CLS_NOP    = 3'd6
  } ins_class_e;

  // Branch decision from the opcode and the ALU zero flag. beq/bne use a
  // subtract; bltz uses slt rs,$0, so zero=0 means rs < 0.
  function automatic logic branch_taken(input logic [5:0] op, input logic zero);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = ~zero;
      OP_BLTZ: taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_if
// Bundle between the control unit (master) and the datapath (slave).
//   opcode, zero                 : datapath -> control
//   state                        : current sequencer state (debug)
//   pc_wre, pc_src               : PC write enable / next-PC select
//   ins_mem_rw, ir_wre           : instruction fetch and IR load
//   reg_wre, reg_dst, wr_reg_d_src : register-file write control
//   alu_src_a, alu_src_b, ext_sel, alu_op : ALU operand/operation control
//   m_rd, m_wr, db_data_src      : data-memory control and write-back mux
// ---------------------------------------------------------------------------
interface multi_cycle_control_if;
  import mcpu_pkg::*;

  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state;
  logic       pc_wre;
  logic [1:0] pc_src;
  logic       ins_mem_rw;
  logic       ir_wre;
  logic       reg_wre;
  logic [1:0] reg_dst;
  logic       wr_reg_d_src;
  logic       alu_src_a;
  logic       alu_src_b;
  logic       ext_sel;
  logic [2:0] alu_op;
  logic       m_rd;
  logic       m_wr;
  logic       db_data_src;

  modport master (
    input  opcode, zero,
    output state, pc_wre, pc_src, ins_mem_rw, ir_wre, reg_wre, reg_dst,
           wr_reg_d_src, alu_src_a, alu_src_b, ext_sel, alu_op,
           m_rd, m_wr, db_data_src
  );

  modport slave (
    output opcode, zero,
    input  state, pc_wre, pc_src, ins_mem_rw, ir_wre, reg_wre, reg_dst,
           wr_reg_d_src, alu_src_a, alu_src_b, ext_sel, alu_op,
           m_rd, m_wr, db_data_src
  );

endinterface

// File: rtl/multi_cycle_control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational opcode decoder.
//   opcode_i    : IR[31:26]
//   cls_o       : instruction class for the sequencer
//   alu_op_o    : ALU operation
//   ext_sel_o   : 0 zero-extend, 1 sign-extend the immediate
//   alu_src_a_o : 1 selects zero-extended sa
//   alu_src_b_o : 1 selects the extended immediate
//   reg_dst_o   : write destination select
// Undefined opcodes decode as a nop.
// ---------------------------------------------------------------------------
module control_decode
  import mcpu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  output ins_class_e  cls_o,
  output logic [2:0]  alu_op_o,
  output logic        ext_sel_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  output logic [1:0]  reg_dst_o
);

  // Opcode to class and static datapath selects
  always_comb begin
    cls_o       = CLS_NOP;
    alu_op_o    = ALU_ADD;
    ext_sel_o   = 1'b1;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    reg_dst_o   = REG_DST_RA;
    case (opcode_i)
      OP_ADD:   begin cls_o = CLS_ALU; reg_dst_o = REG_DST_RD; end
      OP_SUB:   begin cls_o = CLS_ALU; alu_op_o = ALU_SUB; reg_dst_o = REG_DST_RD; end
      OP_ADDIU: begin cls_o = CLS_ALU; alu_src_b_o = 1'b1; reg_dst_o = REG_DST_RT; end
      OP_AND:   begin cls_o = CLS_ALU; alu_op_o = ALU_AND; reg_dst_o = REG_DST_RD; end
      OP_ANDI:  begin
        cls_o = CLS_ALU; alu_op_o = ALU_AND; ext_sel_o = 1'b0;
        alu_src_b_o = 1'b1; reg_dst_o = REG_DST_RT;
      end
      OP_OR:    begin cls_o = CLS_ALU; alu_op_o = ALU_OR; reg_dst_o = REG_DST_RD; end
      OP_ORI:   begin
        cls_o = CLS_ALU; alu_op_o = ALU_OR; ext_sel_o = 1'b0;
        alu_src_b_o = 1'b1; reg_dst_o = REG_DST_RT;
      end
      OP_XORI:  begin
        cls_o = CLS_ALU; alu_op_o = ALU_XOR; ext_sel_o = 1'b0;
        alu_src_b_o = 1'b1; reg_dst_o = REG_DST_RT;
      end
      OP_SLL:   begin
        cls_o = CLS_ALU; alu_op_o = ALU_SLL; alu_src_a_o = 1'b1; reg_dst_o = REG_DST_RD;
      end
      OP_SLT:   begin cls_o = CLS_ALU; alu_op_o = ALU_SLT; reg_dst_o = REG_DST_RD; end
      OP_SLTI:  begin
        cls_o = CLS_ALU; alu_op_o = ALU_SLT; alu_src_b_o = 1'b1; reg_dst_o = REG_DST_RT;
      end
      OP_LW:    begin cls_o = CLS_LOAD;  alu_src_b_o = 1'b1; reg_dst_o = REG_DST_RT; end
      OP_SW:    begin cls_o = CLS_STORE; alu_src_b_o = 1'b1; end
      OP_BEQ:   begin cls_o = CLS_BRANCH; alu_op_o = ALU_SUB; end
      OP_BNE:   begin cls_o = CLS_BRANCH; alu_op_o = ALU_SUB; end
      OP_BLTZ:  begin cls_o = CLS_BRANCH; alu_op_o = ALU_SLT; end
      OP_J:     cls_o = CLS_JUMP;
      OP_JR:    cls_o = CLS_JUMP;
      OP_JAL:   cls_o = CLS_JUMP;
      OP_HALT:  cls_o = CLS_HALT;
      default:  cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
// Multi-cycle MIPS control sequencer: steps IF/ID/EXE/MEM/WB per opcode and
// drives all datapath control for the current cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (state forced to IF)
//   bus   : master side of multi_cycle_control_if (opcode/zero in, controls out)
// All outputs are combinational from the state register and opcode; pc_src
// additionally follows zero in EXE_BR so the branch resolves in that cycle.
// ---------------------------------------------------------------------------
module multi_cycle_control
  import mcpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  multi_cycle_control_if.master    bus
);

  state_e     state_q;
  state_e     state_d;

  ins_class_e cls_s;
  logic [2:0] dec_alu_op_s;
  logic       dec_ext_sel_s;
  logic       dec_alu_src_a_s;
  logic       dec_alu_src_b_s;
  logic [1:0] dec_reg_dst_s;

  logic       pc_wre_s;
  logic [1:0] pc_src_s;
  logic       ins_mem_rw_s;
  logic       ir_wre_s;
  logic       reg_wre_s;
  logic [1:0] reg_dst_s;
  logic       wr_reg_d_src_s;
  logic       alu_src_a_s;
  logic       alu_src_b_s;
  logic [2:0] alu_op_s;
  logic       m_rd_s;
  logic       m_wr_s;
  logic       db_data_src_s;

  control_decode u_decode (
    .opcode_i    (bus.opcode),
    .cls_o       (cls_s),
    .alu_op_o    (dec_alu_op_s),
    .ext_sel_o   (dec_ext_sel_s),
    .alu_src_a_o (dec_alu_src_a_s),
    .alu_src_b_o (dec_alu_src_b_s),
    .reg_dst_o   (dec_reg_dst_s)
  );

  // State register; reset drops straight back to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing by instruction class
  always_comb begin
    state_d = ST_IF;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        case (cls_s)
          CLS_ALU:    state_d = ST_EXE_AL;
          CLS_LOAD:   state_d = ST_EXE_LS;
          CLS_STORE:  state_d = ST_EXE_LS;
          CLS_BRANCH: state_d = ST_EXE_BR;
          CLS_HALT:   state_d = ST_ID;   // parks here until reset
          CLS_JUMP:   state_d = ST_IF;
          CLS_NOP:    state_d = ST_IF;
          default:    state_d = ST_IF;
        endcase
      end
      ST_EXE_AL: state_d = ST_WB_AL;
      ST_WB_AL:  state_d = ST_IF;
      ST_EXE_BR: state_d = ST_IF;
      ST_EXE_LS: state_d = ST_MEM;
      ST_MEM: begin
        if (cls_s == CLS_LOAD) begin
          state_d = ST_WB_L;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_WB_L:   state_d = ST_IF;
      default:   state_d = ST_IF;
    endcase
  end

  // Per-state control outputs; every write enable is tied to one final cycle
  always_comb begin
    pc_wre_s       = 1'b0;
    pc_src_s       = PC_SRC_SEQ;
    ins_mem_rw_s   = 1'b0;
    ir_wre_s       = 1'b0;
    reg_wre_s      = 1'b0;
    wr_reg_d_src_s = 1'b0;
    m_rd_s         = 1'b0;
    m_wr_s         = 1'b0;
    db_data_src_s  = 1'b0;

    // Static selects only follow the opcode once IR holds a valid instruction
    if (state_q != ST_IF) begin
      alu_op_s    = dec_alu_op_s;
      alu_src_a_s = dec_alu_src_a_s;
      alu_src_b_s = dec_alu_src_b_s;
      reg_dst_s   = dec_reg_dst_s;
    end else begin
      alu_op_s    = ALU_ADD;
      alu_src_a_s = 1'b0;
      alu_src_b_s = 1'b0;
      reg_dst_s   = REG_DST_RA;
    end

    case (state_q)
      ST_IF: begin
        ins_mem_rw_s = 1'b1;
        ir_wre_s     = 1'b1;
      end
      ST_ID: begin
        case (cls_s)
          CLS_JUMP: begin
            pc_wre_s = 1'b1;
            if (bus.opcode == OP_JR) begin
              pc_src_s = PC_SRC_RS;
            end else begin
              pc_src_s = PC_SRC_JUMP;
            end
            // jal links PC+4 into $31 in the same cycle it jumps
            if (bus.opcode == OP_JAL) begin
              reg_wre_s      = 1'b1;
              wr_reg_d_src_s = 1'b0;
            end else begin
              reg_wre_s      = 1'b0;
            end
          end
          CLS_NOP:  pc_wre_s = 1'b1;
          default:  pc_wre_s = 1'b0;
        endcase
      end
      ST_EXE_BR: begin
        pc_wre_s = 1'b1;
        if (branch_taken(bus.opcode, bus.zero)) begin
          pc_src_s = PC_SRC_BRANCH;
        end else begin
          pc_src_s = PC_SRC_SEQ;
        end
      end
      ST_MEM: begin
        if (cls_s == CLS_LOAD) begin
          m_rd_s = 1'b1;
        end else begin
          m_wr_s   = 1'b1;
          pc_wre_s = 1'b1;
        end
      end
      ST_WB_AL: begin
        pc_wre_s       = 1'b1;
        reg_wre_s      = 1'b1;
        wr_reg_d_src_s = 1'b1;
      end
      ST_WB_L: begin
        pc_wre_s       = 1'b1;
        reg_wre_s      = 1'b1;
        wr_reg_d_src_s = 1'b1;
        db_data_src_s  = 1'b1;
      end
      ST_EXE_AL: pc_wre_s = 1'b0;
      ST_EXE_LS: pc_wre_s = 1'b0;
      default:   pc_wre_s = 1'b0;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.pc_wre       = pc_wre_s;
  assign bus.pc_src       = pc_src_s;
  assign bus.ins_mem_rw   = ins_mem_rw_s;
  assign bus.ir_wre       = ir_wre_s;
  assign bus.reg_wre      = reg_wre_s;
  assign bus.reg_dst      = reg_dst_s;
  assign bus.wr_reg_d_src = wr_reg_d_src_s;
  assign bus.alu_src_a    = alu_src_a_s;
  assign bus.alu_src_b    = alu_src_b_s;
  assign bus.ext_sel      = dec_ext_sel_s;
  assign bus.alu_op       = alu_op_s;
  assign bus.m_rd         = m_rd_s;
  assign bus.m_wr         = m_wr_s;
  assign bus.db_data_src  = db_data_src_s;

endmodule

// File: tb/tb_multi_cycle_control.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control
// Per-cycle vector table for complete instructions, plus hand-written
// sequences for reset mid-instruction and halt.
// Expected word layout (21 bits):
//   state _ pc_wre pc_src _ ins_mem_rw ir_wre _ reg_wre reg_dst wr_reg_d_src _
//   alu_src_a alu_src_b ext_sel alu_op _ m_rd m_wr db_data_src
// ---------------------------------------------------------------------------
module tb_multi_cycle_control;

  typedef struct packed {
    logic [5:0]  op;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  multi_cycle_control_if bus_if();

  multi_cycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [20:0] V_IF1 = 21'b000_0_00_1_1_0_00_0_0_0_1_000_0_0_0;
  localparam logic [20:0] V_IF0 = 21'b000_0_00_1_1_0_00_0_0_0_0_000_0_0_0;
  localparam logic [20:0] V_HLT = 21'b001_0_00_0_0_0_00_0_0_0_1_000_0_0_0;
  localparam logic [20:0] V_EXA = 21'b110_0_00_0_0_0_10_0_0_0_1_000_0_0_0;

  function automatic logic [20:0] obs();
    return {bus_if.state, bus_if.pc_wre, bus_if.pc_src, bus_if.ins_mem_rw,
            bus_if.ir_wre, bus_if.reg_wre, bus_if.reg_dst, bus_if.wr_reg_d_src,
            bus_if.alu_src_a, bus_if.alu_src_b, bus_if.ext_sel, bus_if.alu_op,
            bus_if.m_rd, bus_if.m_wr, bus_if.db_data_src};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic z, input logic [20:0] e);
    vec_t v;
    v.op  = op;
    v.z   = z;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s op=%b got=%b exp=%b", name, bus_if.opcode, got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // add: IF ID EXE_AL WB_AL
    vecs.push_back(mk(6'b000000, 1'b0, V_IF1));
    vecs.push_back(mk(6'b000000, 1'b0, 21'b001_0_00_0_0_0_10_0_0_0_1_000_0_0_0));
    vecs.push_back(mk(6'b000000, 1'b0, 21'b110_0_00_0_0_0_10_0_0_0_1_000_0_0_0));
    vecs.push_back(mk(6'b000000, 1'b0, 21'b111_1_00_0_0_1_10_1_0_0_1_000_0_0_0));
    // lw: IF ID EXE_LS MEM WB_L
    vecs.push_back(mk(6'b110001, 1'b0, V_IF1));
    vecs.push_back(mk(6'b110001, 1'b0, 21'b001_0_00_0_0_0_01_0_0_1_1_000_0_0_0));
    vecs.push_back(mk(6'b110001, 1'b0, 21'b010_0_00_0_0_0_01_0_0_1_1_000_0_0_0));
    vecs.push_back(mk(6'b110001, 1'b0, 21'b011_0_00_0_0_0_01_0_0_1_1_000_1_0_0));
    vecs.push_back(mk(6'b110001, 1'b0, 21'b100_1_00_0_0_1_01_1_0_1_1_000_0_0_1));
    // sw: IF ID EXE_LS MEM
    vecs.push_back(mk(6'b110000, 1'b1, V_IF1));
    vecs.push_back(mk(6'b110000, 1'b1, 21'b001_0_00_0_0_0_00_0_0_1_1_000_0_0_0));
    vecs.push_back(mk(6'b110000, 1'b1, 21'b010_0_00_0_0_0_00_0_0_1_1_000_0_0_0));
    vecs.push_back(mk(6'b110000, 1'b1, 21'b011_1_00_0_0_0_00_0_0_1_1_000_0_1_0));
    // beq zero=1: taken
    vecs.push_back(mk(6'b110100, 1'b1, V_IF1));
    vecs.push_back(mk(6'b110100, 1'b1, 21'b001_0_00_0_0_0_00_0_0_0_1_001_0_0_0));
    vecs.push_back(mk(6'b110100, 1'b1, 21'b101_1_01_0_0_0_00_0_0_0_1_001_0_0_0));
    // beq zero=0: not taken
    vecs.push_back(mk(6'b110100, 1'b0, V_IF1));
    vecs.push_back(mk(6'b110100, 1'b0, 21'b001_0_00_0_0_0_00_0_0_0_1_001_0_0_0));
    vecs.push_back(mk(6'b110100, 1'b0, 21'b101_1_00_0_0_0_00_0_0_0_1_001_0_0_0));
    // bne zero=0: taken
    vecs.push_back(mk(6'b110101, 1'b0, V_IF1));
    vecs.push_back(mk(6'b110101, 1'b0, 21'b001_0_00_0_0_0_00_0_0_0_1_001_0_0_0));
    vecs.push_back(mk(6'b110101, 1'b0, 21'b101_1_01_0_0_0_00_0_0_0_1_001_0_0_0));
    // bne zero=1: not taken
    vecs.push_back(mk(6'b110101, 1'b1, V_IF1));
    vecs.push_back(mk(6'b110101, 1'b1, 21'b001_0_00_0_0_0_00_0_0_0_1_001_0_0_0));
    vecs.push_back(mk(6'b110101, 1'b1, 21'b101_1_00_0_0_0_00_0_0_0_1_001_0_0_0));
    // bltz zero=0: taken
    vecs.push_back(mk(6'b110110, 1'b0, V_IF1));
    vecs.push_back(mk(6'b110110, 1'b0, 21'b001_0_00_0_0_0_00_0_0_0_1_110_0_0_0));
    vecs.push_back(mk(6'b110110, 1'b0, 21'b101_1_01_0_0_0_00_0_0_0_1_110_0_0_0));
    // jal
    vecs.push_back(mk(6'b111010, 1'b0, V_IF1));
    vecs.push_back(mk(6'b111010, 1'b0, 21'b001_1_11_0_0_1_00_0_0_0_1_000_0_0_0));
    // jr
    vecs.push_back(mk(6'b111001, 1'b0, V_IF1));
    vecs.push_back(mk(6'b111001, 1'b0, 21'b001_1_10_0_0_0_00_0_0_0_1_000_0_0_0));
    // j
    vecs.push_back(mk(6'b111000, 1'b0, V_IF1));
    vecs.push_back(mk(6'b111000, 1'b0, 21'b001_1_11_0_0_0_00_0_0_0_1_000_0_0_0));
    // undefined opcode: nop, PC+4, no writes
    vecs.push_back(mk(6'b101010, 1'b0, V_IF1));
    vecs.push_back(mk(6'b101010, 1'b0, 21'b001_1_00_0_0_0_00_0_0_0_1_000_0_0_0));
    // ori: zero-extended immediate into rt
    vecs.push_back(mk(6'b010010, 1'b0, V_IF0));
    vecs.push_back(mk(6'b010010, 1'b0, 21'b001_0_00_0_0_0_01_0_0_1_0_011_0_0_0));
    vecs.push_back(mk(6'b010010, 1'b0, 21'b110_0_00_0_0_0_01_0_0_1_0_011_0_0_0));
    vecs.push_back(mk(6'b010010, 1'b0, 21'b111_1_00_0_0_1_01_1_0_1_0_011_0_0_0));
    // sll: sa operand into rd
    vecs.push_back(mk(6'b011000, 1'b0, V_IF1));
    vecs.push_back(mk(6'b011000, 1'b0, 21'b001_0_00_0_0_0_10_0_1_0_1_010_0_0_0));
    vecs.push_back(mk(6'b011000, 1'b0, 21'b110_0_00_0_0_0_10_0_1_0_1_010_0_0_0));
    vecs.push_back(mk(6'b011000, 1'b0, 21'b111_1_00_0_0_1_10_1_1_0_1_010_0_0_0));

    // Reset state
    rst_n = 1'b0;
    bus_if.opcode = 6'b000000;
    bus_if.zero   = 1'b0;
    #3;
    chk("reset", obs(), V_IF1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one vector per cycle, checked mid-cycle
    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.opcode = vecs[i].op;
      bus_if.zero   = vecs[i].z;
      #1;
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
      @(negedge clk);
    end

    // Reset asserted in EXE_AL of an add
    bus_if.opcode = 6'b000000;
    bus_if.zero   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_exe_al", obs(), V_EXA);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", obs(), V_IF1);

    // Release with halt: IF then park in ID
    @(negedge clk);
    bus_if.opcode = 6'b111111;
    rst_n = 1'b1;
    #1;
    chk("post_rst_if", obs(), V_IF1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("halt%0d", c), obs(), V_HLT);
    end

    // Only reset leaves halt
    rst_n = 1'b0;
    #1;
    chk("halt_rst", obs(), V_IF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
